// File: rtl/seq_alu.sv
// Sequential ALU with a valid/ready handshake on both sides.
// Single-cycle ops finish at acceptance; shifts move one bit per clock.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_DIFF = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_next;
  logic             started;
  logic             accept;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   cnt;
  logic             is_shift;
  logic             multi;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] shift_next;
  logic             shift_out;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff_bits;
  logic [SHW-1:0]   diff_idx;
  logic [WIDTH-1:0] calc_res;
  logic             calc_c;
  logic             calc_v;

  assign accept   = in_valid && in_ready;
  assign amt      = b[SHW-1:0];
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign multi    = is_shift && (amt != '0);

  // started keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      started <= 1'b0;
    end else begin
      state   <= state_next;
      started <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = multi ? BUSY : DONE;
      BUSY:    if (cnt == SHW'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && started;
    out_valid = (state == DONE);
  end

  always_comb begin
    sum       = '0;
    calc_res  = '0;
    calc_c    = 1'b0;
    calc_v    = 1'b0;
    diff_bits = a ^ b;
    diff_idx  = SHW'(WIDTH - 1);
    // descending scan leaves the lowest set index; all-zero keeps WIDTH-1
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff_bits[i]) diff_idx = SHW'(i);
    end
    case (op)
      OP_ADD: begin
        sum      = {1'b0, a} + {1'b0, b};
        calc_res = sum[WIDTH-1:0];
        calc_c   = sum[WIDTH];
        calc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (calc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        calc_res = sum[WIDTH-1:0];
        calc_c   = sum[WIDTH];
        calc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (calc_res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  calc_res = a & b;
      OP_XOR:  calc_res = a ^ b;
      OP_DIFF: calc_res = {{(WIDTH-SHW){1'b0}}, diff_idx};
      default: calc_res = a;  // zero-amount shifts pass a through
    endcase
  end

  // SRA keeps work[WIDTH-1] fixed, so it always holds the original sign
  always_comb begin
    shift_next = work;
    shift_out  = 1'b0;
    case (op_q)
      OP_SLL: begin
        shift_next = {work[WIDTH-2:0], 1'b0};
        shift_out  = work[WIDTH-1];
      end
      OP_SRL: begin
        shift_next = {1'b0, work[WIDTH-1:1]};
        shift_out  = work[0];
      end
      OP_SRA: begin
        shift_next = {work[WIDTH-1], work[WIDTH-1:1]};
        shift_out  = work[0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      work   <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else if (accept) begin
      op_q <= op;
      work <= a;
      cnt  <= amt;
      if (!multi) begin
        result <= calc_res;
        flags  <= {calc_c, calc_v, (calc_res == '0), calc_res[WIDTH-1]};
      end
    end else if (state == BUSY) begin
      work <= shift_next;
      cnt  <= cnt - SHW'(1);
      if (cnt == SHW'(1)) begin
        result <= shift_next;
        flags  <= {shift_out, 1'b0, (shift_next == '0), shift_next[WIDTH-1]};
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): vector table plus hand-written
// sequences for output backpressure and reset during a shift.
module tb_seq_alu;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_DIFF = 3'b111;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [3:0]  flags;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] prev_res = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;   // {carry, overflow, zero, sign}
    int          lat;   // extra edges after accept before out_valid is seen
  } vec_t;

  vec_t vecs [NV];

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] er,
                        input logic [3:0] ef, input int el);
    int lat;
    bit hold_ok;
    bit ready_low;
    @(negedge clk);
    check({name, " in_ready_before"}, 32'(in_ready), 32'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = ~x; b = ~y; op = ~o;
    lat = 0; hold_ok = 1'b1; ready_low = 1'b1;
    while (!out_valid && lat < 100) begin
      if (result !== prev_res) hold_ok = 1'b0;
      if (in_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(el));
    check({name, " result_hold_busy"}, 32'(hold_ok), 32'd1);
    check({name, " in_ready_low_busy"}, 32'(ready_low), 32'd1);
    check({name, " in_ready_low_done"}, 32'(in_ready), 32'd0);
    check({name, " result"}, result, er);
    check({name, " flags"}, 32'(flags), 32'(ef));
    $display("txn %s op=%0d a=0x%08h b=0x%08h result=0x%08h flags=%04b lat=%0d",
             name, o, x, y, result, flags, lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " out_valid_dropped"}, 32'(out_valid), 32'd0);
    check({name, " in_ready_after"}, 32'(in_ready), 32'd1);
    prev_res = er;
  endtask

  initial begin
    bit never_valid;
    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010, 0};
    vecs[1]  = '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1100, 0};
    vecs[2]  = '{OP_SRA,  32'h8000_0010, 32'h0000_0005, 32'hFC00_0000, 4'b1001, 5};
    vecs[3]  = '{OP_DIFF, 32'h0000_000C, 32'h0000_0004, 32'h0000_0003, 4'b0000, 0};
    vecs[4]  = '{OP_DIFF, 32'h0000_0055, 32'h0000_0055, 32'h0000_001F, 4'b0000, 0};
    vecs[5]  = '{OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101, 0};
    vecs[6]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010, 0};
    vecs[7]  = '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 4'b0001, 0};
    vecs[8]  = '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b0001, 0};
    vecs[9]  = '{OP_XOR,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 4'b0010, 0};
    vecs[10] = '{OP_SLL,  32'h0000_0003, 32'h0000_0004, 32'h0000_0030, 4'b0000, 4};
    vecs[11] = '{OP_SRL,  32'h0000_000F, 32'hFFFF_FFE2, 32'h0000_0003, 4'b1000, 2};
    vecs[12] = '{OP_SLL,  32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 4'b0000, 0};
    vecs[13] = '{OP_SRA,  32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF, 4'b0001, 31};
    vecs[14] = '{OP_SLL,  32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 4'b1000, 1};
    vecs[15] = '{OP_DIFF, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b0010, 0};
    vecs[16] = '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 4'b1110, 0};

    // asynchronous reset values, before any clock edge
    #3;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset flags", 32'(flags), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready before first edge", 32'(in_ready), 32'd0);

    for (int i = 0; i < NV; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].flg, vecs[i].lat);
    end

    // XOR under output backpressure with in_valid held high
    @(negedge clk);
    op = OP_XOR; a = 32'hA5A5_A5A5; b = 32'h0F0F_0F0F; in_valid = 1'b1;
    @(negedge clk);
    a = '0; b = '0;
    check("bp out_valid", 32'(out_valid), 32'd1);
    check("bp result", result, 32'hAAAA_AAAA);
    check("bp flags", 32'(flags), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d result", k), result, 32'hAAAA_AAAA);
      check($sformatf("bp stall%0d valid_ready", k), {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp idle in_ready", 32'(in_ready), 32'd1);
    check("bp idle out_valid", 32'(out_valid), 32'd0);
    check("bp idle result", result, 32'hAAAA_AAAA);
    in_valid = 1'b0; out_ready = 1'b0;
    $display("txn backpressure xor result=0x%08h", result);

    // SLL by 20 aborted by reset at cycle 7
    @(negedge clk);
    op = OP_SLL; a = 32'h0000_0001; b = 32'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    never_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (out_valid !== 1'b0) never_valid = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort result", result, 32'd0);
    check("abort flags", 32'(flags), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) never_valid = 1'b0;
    end
    check("abort never valid", 32'(never_valid), 32'd1);
    check("abort result after", result, 32'd0);
    $display("txn aborted sll result=0x%08h", result);
    prev_res = '0;
    run_op("add_after_reset", OP_ADD, 32'd2, 32'd3, 32'd5, 4'b0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width, power of two, 8 or more.
REQ-002 SHALL have derived parameter SHW, default $clog2(WIDTH): shift-amount and index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B; low SHW bits are the shift amount.
REQ-009 SHALL have port op  input  3  opcode.
REQ-010 SHALL have port out_valid  output  1  result and flags valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port result  output  WIDTH  registered result.
REQ-013 SHALL have port flags  output  4  registered {carry, overflow, zero, sign}.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-015 SHALL drive in_ready high only in IDLE; a request is accepted on a rising edge with in_valid && in_ready.
REQ-016 SHALL register a, b and op at acceptance; later input changes SHALL not affect the operation.
REQ-017 SHALL decode opcodes as: 000 ADD a+b; 001 SUB a+~b+1; 010 AND; 011 XOR; 100 SLL; 101 SRL; 110 SRA; 111 DIFF.
REQ-018 SHALL define DIFF as the index of the lowest set bit of a^b, zero-extended to WIDTH, and SHALL return WIDTH-1 when a==b.
REQ-019 SHALL go IDLE->DONE at acceptance for ADD, SUB, AND, XOR and DIFF, so out_valid is high one cycle after the accept edge.
REQ-020 SHALL, for shifts with amount n=b[SHW-1:0] and n>0, go IDLE->BUSY, shift one bit per cycle, decrement a counter, and go BUSY->DONE when the counter reaches 0; out_valid SHALL rise n cycles after the accept edge.
REQ-021 SHALL treat a shift with n=0 as a single-cycle op with result equal to a.
REQ-022 SHALL fill SRA with the original a[WIDTH-1] and fill SLL/SRL with 0.
REQ-023 SHALL set carry to the carry-out for ADD and SUB (SUB: 1 = no borrow), to the last bit shifted out for shifts (0 if n=0), and to 0 otherwise.
REQ-024 SHALL set overflow to signed overflow for ADD and SUB, and to 0 otherwise.
REQ-025 SHALL set zero to (result==0) and sign to result[WIDTH-1] for every op.
REQ-026 SHALL hold out_valid high in DONE with result and flags stable until out_ready is high on a rising edge, and SHALL then go DONE->IDLE.
REQ-027 SHALL ignore in_valid in BUSY and DONE; acceptance is possible at the earliest on the cycle after DONE exits.
REQ-028 SHALL keep result and flags at their last values in IDLE and BUSY; only out_valid qualifies them.

Reset
REQ-029 SHALL, on rst_n low, immediately force IDLE, clear the shift counter, and drive out_valid=0, result=0, flags=0 and in_ready=0, regardless of clk.
REQ-030 SHALL abort any in-progress operation on reset and SHALL never produce its result.
REQ-031 SHALL drive in_ready high from the first clk edge after rst_n deasserts.

Verification (WIDTH=32)
REQ-032 SHALL cover ADD a=0xFFFFFFFF, b=1 -> result 0x00000000, flags carry=1 overflow=0 zero=1 sign=0, out_valid 1 cycle after accept.
REQ-033 SHALL cover SUB a=0x80000000, b=1 -> result 0x7FFFFFFF, carry=1, overflow=1, zero=0, sign=0.
REQ-034 SHALL cover SRA a=0x80000010, b=5 -> result 0xFC000000, carry=1, out_valid exactly 5 cycles after accept, in_ready low throughout.
REQ-035 SHALL cover DIFF a=0x0C, b=0x04 -> result 3; DIFF a=b=0x55 -> result 31, zero=0.
REQ-036 SHALL cover XOR result with out_ready held low 4 cycles and in_valid held high -> result stable, no new accept, IDLE one cycle after the out_ready edge.
REQ-037 SHALL cover SLL with b=20 and rst_n pulsed low at cycle 7 -> out_valid never rises, result=0, and a fresh ADD accepted after reset completes correctly.
